mips_bus_ram_responder: RTL and testbench

MIPS_BUS_RAM_RESPONDER -- requirements
Module: mips_bus_ram_responder

---
 rtl/mips_bus_ram_responder_pkg.sv | 31 +++
 rtl/mips_bus_ram_responder_if.sv | 18 +
 rtl/mips_bus_ram_array.sv | 30 +++
 rtl/mips_bus_ram_responder.sv | 147 ++++++++++++++
 tb/tb_mips_bus_ram_responder.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_bus_ram_responder_pkg.sv
// Shared types and constants for the bus RAM responder: FSM states, access
// kinds, bus widths and the default boot-ROM base address.
package mips_bus_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int BE_W   = DATA_W / 8;
   localparam int CNT_W  = 4;

   localparam logic [ADDR_W-1:0] DEFAULT_BASE_ADDR = 32'hBFC00000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      OP_READ  = 2'd0,
      OP_WRITE = 2'd1,
      OP_BAD   = 2'd2
   } op_t;

   // Simultaneous read and write is an illegal request, not a read.
   function automatic op_t decode_op(input logic rd, input logic wr);
      if (rd && wr)  return OP_BAD;
      else if (wr)   return OP_WRITE;
      else           return OP_READ;
   endfunction

endpackage

// File: rtl/mips_bus_ram_responder_if.sv
// Avalon-style request/response bus between an initiator and the RAM responder.
interface mips_bus_if;
   import mips_bus_pkg::*;

   logic [ADDR_W-1:0] address;
   logic              read;
   logic              write;
   logic [BE_W-1:0]   byteenable;
   logic [DATA_W-1:0] writedata;
   logic              waitrequest;
   logic [DATA_W-1:0] readdata;
   logic              err;

   modport master (output address, read, write, byteenable, writedata,
                   input  waitrequest, readdata, err);
   modport slave  (input  address, read, write, byteenable, writedata,
                   output waitrequest, readdata, err);
endinterface

// File: rtl/mips_bus_ram_array.sv
// Word-wide RAM: one synchronous write port with byte enables, combinational
// read at the same index; no reset, so contents survive rst.
module mips_bus_ram_array
   import mips_bus_pkg::*;
#(
   parameter string INIT_FILE = "",
   parameter int    DEPTH     = 16384,
   localparam int   IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic [IDX_W-1:0]  i_idx,
   input  logic              i_we,
   input  logic [BE_W-1:0]   i_be,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         for (int b = 0; b < BE_W; b++) begin
            if (i_be[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
         end
      end
   end

   assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/mips_bus_ram_responder.sv
// Wait-state RAM responder with range/illegal-request fault flag.
//   state   | meaning
//   IDLE    | no access; waitrequest follows read|write, request latched here
//   WAIT    | counting remaining wait cycles; request must stay asserted
//   ACK     | single response cycle; readdata valid, write commits on its edge
module mips_bus_ram_responder
   import mips_bus_pkg::*;
#(
   parameter string             RAM_INIT_FILE = "",
   parameter logic [ADDR_W-1:0] BASE_ADDR     = DEFAULT_BASE_ADDR,
   parameter int                DEPTH_WORDS   = 16384,
   parameter int                WAIT_CYCLES   = 2
) (
   input  logic     clk,
   input  logic     rst,
   mips_bus_if.slave bus
);

   localparam int              IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

   state_t            r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
   logic [ADDR_W-1:0] r_addr, w_addr_nxt;
   logic [BE_W-1:0]   r_be, w_be_nxt;
   logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
   op_t               r_op, w_op_nxt;
   logic [DATA_W-1:0] r_readdata, w_readdata_nxt;
   logic              r_err, w_err_nxt;

   logic              w_req, w_waitreq, w_we, w_finish, w_in_range;
   op_t               w_cur_op;
   logic [ADDR_W-1:0] w_look_addr, w_offset, w_word;
   logic [DATA_W-1:0] w_rdata;

   assign w_req       = bus.read | bus.write;
   // The live bus address is only consulted in IDLE; afterwards the latched copy rules.
   assign w_look_addr = (r_state == ST_IDLE) ? bus.address : r_addr;
   assign w_cur_op    = (r_state == ST_IDLE) ? decode_op(bus.read, bus.write) : r_op;
   assign w_offset    = w_look_addr - BASE_ADDR;
   assign w_word      = w_offset >> 2;
   assign w_in_range  = (w_look_addr >= BASE_ADDR) && (w_word < ADDR_W'(DEPTH_WORDS));

   mips_bus_ram_array #(
      .INIT_FILE (RAM_INIT_FILE),
      .DEPTH     (DEPTH_WORDS)
   ) u_array (
      .clk     (clk),
      .i_idx   (w_word[IDX_W-1:0]),
      .i_we    (w_we & ~rst),
      .i_be    (r_be),
      .i_wdata (r_wdata),
      .o_rdata (w_rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_addr     <= '0;
         r_be       <= '0;
         r_wdata    <= '0;
         r_op       <= OP_READ;
         r_readdata <= '0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_addr     <= w_addr_nxt;
         r_be       <= w_be_nxt;
         r_wdata    <= w_wdata_nxt;
         r_op       <= w_op_nxt;
         r_readdata <= w_readdata_nxt;
         r_err      <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_addr_nxt     = r_addr;
      w_be_nxt       = r_be;
      w_wdata_nxt    = r_wdata;
      w_op_nxt       = r_op;
      w_readdata_nxt = r_readdata;
      w_err_nxt      = r_err;
      w_waitreq      = 1'b0;
      w_we           = 1'b0;
      w_finish       = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_waitreq = w_req;
            if (w_req) begin
               w_addr_nxt  = bus.address;
               w_be_nxt    = bus.byteenable;
               w_wdata_nxt = bus.writedata;
               w_op_nxt    = w_cur_op;
               w_cnt_nxt   = CNT_LOAD;
               if (CNT_LOAD == '0) begin
                  w_state_nxt = ST_ACK;
                  w_finish    = 1'b1;
               end else begin
                  w_state_nxt = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            w_waitreq = 1'b1;
            if (!w_req) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
               w_err_nxt   = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
               if (r_cnt == CNT_W'(1)) begin
                  w_state_nxt = ST_ACK;
                  w_finish    = 1'b1;
               end
            end
         end
         ST_ACK: begin
            w_we        = (r_op == OP_WRITE) && w_in_range;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase

      // Response data and fault flag are settled on the edge that enters ACK.
      if (w_finish) begin
         if (w_cur_op == OP_BAD) begin
            w_readdata_nxt = '0;
            w_err_nxt      = 1'b1;
         end else if (!w_in_range) begin
            w_err_nxt = 1'b1;
            if (w_cur_op == OP_READ) w_readdata_nxt = '0;
         end else if (w_cur_op == OP_READ) begin
            w_readdata_nxt = w_rdata;
         end
      end
   end

   assign bus.waitrequest = rst | w_waitreq;
   assign bus.readdata    = r_readdata;
   assign bus.err         = r_err;

endmodule

// File: tb/tb_mips_bus_ram_responder.sv
// Directed plus randomized bench for the RAM responder; two instances cover
// WAIT_CYCLES=2 (default map) and WAIT_CYCLES=1 (back-to-back timing).
module tb_mips_bus_ram_responder;
   import mips_bus_pkg::*;

   localparam logic [31:0] BASE = 32'hBFC00000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mips_bus_if a_if ();
   mips_bus_if b_if ();

   mips_bus_ram_responder #(
      .RAM_INIT_FILE (""),
      .BASE_ADDR     (BASE),
      .DEPTH_WORDS   (16384),
      .WAIT_CYCLES   (2)
   ) u_dut_a (
      .clk (clk),
      .rst (rst),
      .bus (a_if.slave)
   );

   mips_bus_ram_responder #(
      .RAM_INIT_FILE (""),
      .BASE_ADDR     (BASE),
      .DEPTH_WORDS   (64),
      .WAIT_CYCLES   (1)
   ) u_dut_b (
      .clk (clk),
      .rst (rst),
      .bus (b_if.slave)
   );

   int checks = 0;
   int errors = 0;

   // Reference memory: word index -> contents, only for words the bench has written.
   logic [31:0] model_a [int];
   logic [31:0] model_b [int];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] be);
      logic [31:0] res;
      res = old;
      for (int b = 0; b < 4; b++) if (be[b]) res[8*b +: 8] = d[8*b +: 8];
      return res;
   endfunction

   // One bus access. Called just after a rising edge; returns just after the
   // edge that ends the ack cycle. Bus inputs are scrambled once the request
   // has been taken, since the responder must use its latched copies.
   task automatic acc(virtual mips_bus_if vif, input logic rd, input logic wr,
                      input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd,
                      output logic [31:0] rdat, output int nw, output logic e);
      vif.read       = rd;
      vif.write      = wr;
      vif.address    = addr;
      vif.byteenable = be;
      vif.writedata  = wd;
      nw = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (!vif.waitrequest) break;
         nw++;
         @(posedge clk);
         #1;
         vif.address    = $urandom;
         vif.writedata  = $urandom;
         vif.byteenable = 4'($urandom);
      end
      rdat = vif.readdata;
      e    = vif.err;
      @(posedge clk);
      #1;
      vif.read  = 1'b0;
      vif.write = 1'b0;
   endtask

   task automatic wr_a(input int idx, input logic [3:0] be, input logic [31:0] d);
      logic [31:0] rd_v;
      int          nw;
      logic        e;
      acc(a_if, 1'b0, 1'b1, BASE + 32'(4 * idx), be, d, rd_v, nw, e);
      model_a[idx] = merge(model_a.exists(idx) ? model_a[idx] : 32'h0, d, be);
   endtask

   task automatic rd_a(input string tag, input int idx);
      logic [31:0] rd_v;
      int          nw;
      logic        e;
      acc(a_if, 1'b1, 1'b0, BASE + 32'(4 * idx) + 32'($urandom_range(0, 3)), 4'h0, 32'h0,
          rd_v, nw, e);
      check(tag, rd_v, model_a[idx]);
      check({tag, "_waits"}, 32'(nw), 32'd2);
   endtask

   task automatic pulse_rst();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] rd_v;
      int          nw;
      logic        e;
      logic [31:0] d;
      logic [3:0]  be;
      int          idx;

      rst = 1'b1;
      a_if.read = 1'b0; a_if.write = 1'b0; a_if.address = '0; a_if.byteenable = '0; a_if.writedata = '0;
      b_if.read = 1'b0; b_if.write = 1'b0; b_if.address = '0; b_if.byteenable = '0; b_if.writedata = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_waitreq", 32'(a_if.waitrequest), 32'd1);
      check("rst_readdata", a_if.readdata, 32'h0);
      check("rst_err", 32'(a_if.err), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Read after reset: contents survive rst, two wait cycles then data.
      wr_a(0, 4'hF, 32'h12345678);
      pulse_rst();
      acc(a_if, 1'b1, 1'b0, BASE, 4'h0, 32'h0, rd_v, nw, e);
      check("first_read_waits", 32'(nw), 32'd2);
      check("first_read_data", rd_v, 32'h12345678);
      check("first_read_err", 32'(e), 32'd0);

      // Byte-masked write.
      wr_a(1, 4'hF, 32'hAABBCCDD);
      wr_a(1, 4'b0101, 32'h11223344);
      acc(a_if, 1'b1, 1'b0, BASE + 32'd4, 4'h0, 32'h0, rd_v, nw, e);
      check("bemask_data", rd_v, 32'hAA22CC44);
      check("bemask_model", rd_v, model_a[1]);

      // Out of range read, then out of range write aliasing word 0 if unchecked.
      acc(a_if, 1'b1, 1'b0, 32'h00000000, 4'h0, 32'h0, rd_v, nw, e);
      check("oor_read_data", rd_v, 32'h0);
      check("oor_read_err", 32'(e), 32'd1);
      acc(a_if, 1'b0, 1'b1, 32'hBFC10000, 4'hF, 32'hDEADBEEF, rd_v, nw, e);
      check("oor_write_waits", 32'(nw), 32'd2);
      check("oor_write_err", 32'(e), 32'd1);
      rd_a("oor_word0", 0);
      check("oor_err_sticky", 32'(a_if.err), 32'd1);
      pulse_rst();
      check("err_cleared", 32'(a_if.err), 32'd0);

      // Zero byteenable write changes nothing and is not a fault.
      acc(a_if, 1'b0, 1'b1, BASE + 32'd4, 4'h0, 32'hFFFFFFFF, rd_v, nw, e);
      check("be0_err", 32'(e), 32'd0);
      rd_a("be0_word1", 1);

      // Abort: request withdrawn during WAIT.
      wr_a(2, 4'hF, 32'h55667788);
      a_if.write = 1'b1; a_if.address = BASE + 32'd8; a_if.byteenable = 4'hF;
      a_if.writedata = 32'hFFFFFFFF;
      @(posedge clk);
      #1;
      a_if.write = 1'b0;
      @(negedge clk);
      check("abort_wait_high", 32'(a_if.waitrequest), 32'd1);
      @(posedge clk);
      #1;
      check("abort_idle_waitreq", 32'(a_if.waitrequest), 32'd0);
      check("abort_err", 32'(a_if.err), 32'd1);
      rd_a("abort_word2", 2);
      pulse_rst();

      // Reset during WAIT of a write.
      wr_a(3, 4'hF, 32'h99AABBCC);
      rd_a("pre_rst_word2", 2);
      a_if.write = 1'b1; a_if.address = BASE + 32'd12; a_if.byteenable = 4'hF;
      a_if.writedata = 32'h00000000;
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("midrst_waitreq", 32'(a_if.waitrequest), 32'd1);
      check("midrst_readdata", a_if.readdata, 32'h0);
      @(posedge clk);
      #1;
      a_if.write = 1'b0;
      check("midrst_waitreq_hold", 32'(a_if.waitrequest), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      rd_a("midrst_word3", 3);

      // Read and write together: illegal, no effect, readdata cleared.
      acc(a_if, 1'b1, 1'b1, BASE + 32'd12, 4'hF, 32'h0, rd_v, nw, e);
      check("both_readdata", rd_v, 32'h0);
      check("both_err", 32'(e), 32'd1);
      rd_a("both_word3", 3);
      pulse_rst();

      // Randomized traffic against the model.
      for (int i = 4; i < 16; i++) wr_a(i, 4'hF, $urandom);
      for (int i = 0; i < 40; i++) begin
         idx = $urandom_range(0, 15);
         if ($urandom_range(0, 1) == 1) begin
            d  = $urandom;
            be = 4'($urandom);
            wr_a(idx, be, d);
         end else begin
            rd_a($sformatf("rand_rd_%0d", idx), idx);
         end
      end
      check("rand_err", 32'(a_if.err), 32'd0);

      // Back-to-back reads on the single-wait instance.
      for (int i = 0; i < 4; i++) begin
         d = $urandom;
         acc(b_if, 1'b0, 1'b1, BASE + 32'(4 * i), 4'hF, d, rd_v, nw, e);
         model_b[i] = d;
      end
      for (int i = 0; i < 4; i++) begin
         acc(b_if, 1'b1, 1'b0, BASE + 32'(4 * i), 4'h0, 32'h0, rd_v, nw, e);
         check($sformatf("b2b_data_%0d", i), rd_v, model_b[i]);
         check($sformatf("b2b_waits_%0d", i), 32'(nw), 32'd1);
      end
      check("b2b_err", 32'(b_if.err), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
